// File: rtl/fir_poly_sample_interleaver.sv
// Buffers decimated 2-channel FIR output pairs in a FIFO and streams them out
// as interleaved A,B words over a valid/ready handshake with sticky overflow.
module fir_poly_sample_interleaver #(
  parameter int OUTPUT_WIDTH = 14,
  parameter int DEPTH        = 16,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_2mhz_pos_en,
  input  logic                           din_valid,
  input  logic signed [OUTPUT_WIDTH-1:0] din_a,
  input  logic signed [OUTPUT_WIDTH-1:0] din_b,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           dout_chan,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [DEPTH_LOG2:0]            fill,
  output logic                           overflow,
  input  logic                           overflow_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHAN_A = 2'd1,
    CHAN_B = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  state_t                        state;
  state_t                        state_next;
  logic [2*OUTPUT_WIDTH-1:0]     mem [DEPTH];
  logic [2*OUTPUT_WIDTH-1:0]     head;
  logic [DEPTH_LOG2-1:0]         wr_ptr;
  logic [DEPTH_LOG2-1:0]         rd_ptr;
  logic [DEPTH_LOG2:0]           fill_next;
  logic                          push_req;
  logic                          push_acc;
  logic                          pop;

  assign push_req = din_valid & clk_2mhz_pos_en;
  assign pop      = (state == CHAN_B) & dout_ready;
  // A full FIFO can still take a pair when the head leaves on the same edge.
  assign push_acc = push_req & ((fill != FULL) | pop);
  assign head     = mem[rd_ptr];

  // Occupancy after this edge.
  always_comb begin
    fill_next = fill;
    case ({push_acc, pop})
      2'b10:   fill_next = fill + (DEPTH_LOG2 + 1)'(1);
      2'b01:   fill_next = fill - (DEPTH_LOG2 + 1)'(1);
      default: fill_next = fill;
    endcase
  end

  // Pair storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= {din_a, din_b};
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      fill <= fill_next;
      if (push_req && !push_acc) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output FSM next state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fill != '0) begin
          state_next = CHAN_A;
        end else begin
          state_next = IDLE;
        end
      end
      CHAN_A: begin
        if (dout_ready) begin
          state_next = CHAN_B;
        end else begin
          state_next = CHAN_A;
        end
      end
      CHAN_B: begin
        if (!dout_ready) begin
          state_next = CHAN_B;
        end else if (fill_next != '0) begin
          state_next = CHAN_A;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; words are zero whenever nothing is offered.
  always_comb begin
    dout       = '0;
    dout_chan  = 1'b0;
    dout_valid = 1'b0;
    case (state)
      CHAN_A: begin
        dout       = head[2*OUTPUT_WIDTH-1:OUTPUT_WIDTH];
        dout_chan  = 1'b0;
        dout_valid = 1'b1;
      end
      CHAN_B: begin
        dout       = head[OUTPUT_WIDTH-1:0];
        dout_chan  = 1'b1;
        dout_valid = 1'b1;
      end
      default: begin
        dout       = '0;
        dout_chan  = 1'b0;
        dout_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_poly_sample_interleaver.sv
// Directed bench for fir_poly_sample_interleaver: vector table for the basic
// handshake plus scoreboarded sequences for streaming, full/overflow and reset.
module tb_fir_poly_sample_interleaver;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_2mhz_pos_en;
  logic        din_valid;
  logic [13:0] din_a;
  logic [13:0] din_b;
  logic [13:0] dout;
  logic        dout_chan;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  fill;
  logic        overflow;
  logic        overflow_clr;

  int total = 0;
  int bad   = 0;
  logic [14:0] exp_q[$];
  int          words_seen;

  typedef struct {
    logic        push;
    logic [13:0] a;
    logic [13:0] b;
    logic        ready;
    logic        ev;
    logic        ec;
    logic [13:0] ed;
    logic [4:0]  ef;
  } vec_t;

  vec_t vt[11];

  fir_poly_sample_interleaver #(
    .OUTPUT_WIDTH(14),
    .DEPTH(16),
    .DEPTH_LOG2(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_2mhz_pos_en(clk_2mhz_pos_en),
    .din_valid(din_valid),
    .din_a(din_a),
    .din_b(din_b),
    .dout(dout),
    .dout_chan(dout_chan),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .fill(fill),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, score any word handed over at the coming edge.
  task automatic step(input logic p, input logic [13:0] a, input logic [13:0] b,
                      input logic r, input logic c, input logic acc);
    @(negedge clk);
    din_valid       = p;
    clk_2mhz_pos_en = p;
    din_a           = a;
    din_b           = b;
    dout_ready      = r;
    overflow_clr    = c;
    if (dout_valid && dout_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", {17'd0, dout_chan, dout}, 32'h7fff);
      end else begin
        check("word", {17'd0, dout_chan, dout}, {17'd0, exp_q.pop_front()});
      end
    end
    if (p && acc) begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b1, b});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          maxf;
    logic [13:0] ta;
    logic [13:0] tb;

    vt[0]  = '{1'b1, 14'h0123, 14'h3FFB, 1'b1, 1'b0, 1'b0, 14'h0000, 5'd1};
    vt[1]  = '{1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, 1'b0, 14'h0123, 5'd1};
    vt[2]  = '{1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, 1'b1, 14'h3FFB, 5'd1};
    vt[3]  = '{1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h0000, 5'd0};
    vt[4]  = '{1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h0000, 5'd0};
    vt[5]  = '{1'b1, 14'h1FFF, 14'h2000, 1'b0, 1'b0, 1'b0, 14'h0000, 5'd1};
    vt[6]  = '{1'b0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h1FFF, 5'd1};
    vt[7]  = '{1'b0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h1FFF, 5'd1};
    vt[8]  = '{1'b0, 14'h0000, 14'h0000, 1'b1, 1'b1, 1'b1, 14'h2000, 5'd1};
    vt[9]  = '{1'b0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b1, 14'h2000, 5'd1};
    vt[10] = '{1'b0, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h0000, 5'd0};

    words_seen      = 0;
    rst             = 1'b1;
    din_valid       = 1'b0;
    clk_2mhz_pos_en = 1'b0;
    din_a           = '0;
    din_b           = '0;
    dout_ready      = 1'b0;
    overflow_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout", {18'd0, dout}, 32'd0);
    check("rst_chan", {31'd0, dout_chan}, 32'd0);
    check("rst_fill", {27'd0, fill}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: single pair latency, handshake and stall hold.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      din_valid       = vt[i].push;
      clk_2mhz_pos_en = vt[i].push;
      din_a           = vt[i].a;
      din_b           = vt[i].b;
      dout_ready      = vt[i].ready;
      overflow_clr    = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), {31'd0, dout_valid}, {31'd0, vt[i].ev});
      check($sformatf("vec%0d_chan", i), {31'd0, dout_chan}, {31'd0, vt[i].ec});
      check($sformatf("vec%0d_dout", i), {18'd0, dout}, {18'd0, vt[i].ed});
      check($sformatf("vec%0d_fill", i), {27'd0, fill}, {27'd0, vt[i].ef});
      check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, 32'd0);
    end

    // Streaming at the decimated rate with the consumer always ready.
    words_seen = 0;
    maxf       = 0;
    for (int i = 0; i < 1020; i++) begin
      if (i % 20 == 0 && i / 20 < 50) begin
        ta = 14'(i / 20);
        tb = 14'h3FFF - 14'(i / 20);
        step(1'b1, ta, tb, 1'b1, 1'b0, 1'b1);
      end else begin
        step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0, 1'b0);
      end
      if (int'(fill) > maxf) maxf = int'(fill);
    end
    check("stream_words", words_seen, 32'd100);
    check("stream_left", exp_q.size(), 32'd0);
    check("stream_maxfill", maxf, 32'd1);
    check("stream_ovf", {31'd0, overflow}, 32'd0);

    // Fill to capacity with the consumer stalled; the 17th pair is dropped.
    for (int i = 0; i < 17; i++) begin
      ta = 14'h0100 + 14'(i);
      tb = 14'h0000 - 14'(i + 1);
      step(1'b1, ta, tb, 1'b0, 1'b0, (i < 16));
      if (i == 15) begin
        check("full_fill", {27'd0, fill}, 32'd16);
        check("full_ovf_before", {31'd0, overflow}, 32'd0);
      end
    end
    check("drop_fill", {27'd0, fill}, 32'd16);
    check("drop_ovf", {31'd0, overflow}, 32'd1);

    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1, 1'b0);
    check("clr_alone", {31'd0, overflow}, 32'd0);
    step(1'b1, 14'h0AAA, 14'h1555, 1'b0, 1'b1, 1'b0);
    check("clr_vs_set", {31'd0, overflow}, 32'd1);
    check("clr_vs_set_fill", {27'd0, fill}, 32'd16);
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1, 1'b0);
    check("clr_again", {31'd0, overflow}, 32'd0);

    // Push while full coinciding with the CHAN_B pop.
    step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0, 1'b0);
    check("pre_pop_chan", {31'd0, dout_chan}, 32'd1);
    step(1'b1, 14'h2345, 14'h3456, 1'b1, 1'b0, 1'b1);
    check("fullpush_fill", {27'd0, fill}, 32'd16);
    check("fullpush_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 40; i++) step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0, 1'b0);
    check("drain_left", exp_q.size(), 32'd0);
    check("drain_fill", {27'd0, fill}, 32'd0);
    check("drain_valid", {31'd0, dout_valid}, 32'd0);
    check("drain_ovf", {31'd0, overflow}, 32'd0);

    // Reset between the A and B words of a pair.
    step(1'b1, 14'h1111, 14'h2222, 1'b0, 1'b0, 1'b1);
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0, 1'b0);
    check("mid_chan_b", {31'd0, dout_chan}, 32'd1);
    @(negedge clk);
    dout_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("mid_rst_dout", {18'd0, dout}, 32'd0);
    check("mid_rst_chan", {31'd0, dout_chan}, 32'd0);
    check("mid_rst_fill", {27'd0, fill}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    words_seen = 0;
    step(1'b1, 14'h3333, 14'h0444, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0, 1'b0);
    check("post_rst_words", words_seen, 32'd2);
    check("post_rst_left", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
